opcode_fetch: RTL

//  Byte-wide instruction prefetcher. Feeds opcodes to the microcode sequencer
//  (the producer side of its opcode/mc__more_2a/mc__stall interface).

---
 rtl/opcode_fetch_if.sv | 26 ++
 rtl/opcode_fetch.sv | 124 ++++++++++++
 2 files changed

// File: rtl/opcode_fetch_if.sv
// Fetcher-side bundle: memory req/ack port, sequencer opcode handoff and redirect.
// master = the prefetcher, slave = the memory/sequencer/kill side facing it.
interface opcode_fetch_if #(
    parameter int ADDR_W = 32
);
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [7:0]        mem_rdata;
    logic              mc__more_2a;
    logic              mc__stall;
    logic [7:0]        opcode;
    logic              opcode_valid;
    logic [ADDR_W-1:0] opcode_pc;

    modport master (
        input  redirect, redirect_pc, mem_ack, mem_rdata, mc__more_2a, mc__stall,
        output mem_req, mem_addr, opcode, opcode_valid, opcode_pc
    );
    modport slave (
        output redirect, redirect_pc, mem_ack, mem_rdata, mc__more_2a, mc__stall,
        input  mem_req, mem_addr, opcode, opcode_valid, opcode_pc
    );
endinterface

// File: rtl/opcode_fetch.sv
// Byte-wide instruction prefetcher: fetches over req/ack into a small FIFO and
// presents the head to the microcode sequencer; flushes and refetches on redirect.
module opcode_fetch #(
    parameter int              DEPTH      = 4,
    parameter int              ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [7:0]      NOP_OPCODE = 8'h00
) (
    input  logic clk,
    input  logic rst_b,
    opcode_fetch_if.master bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

    state_t            state, state_nxt;
    logic              armed;
    logic [ADDR_W-1:0] addr, addr_nxt;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc;
    logic [7:0]        fifo [DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count, count_nxt;
    logic              req, take, push, pop, space_after;

    // In IDLE the request is raised combinationally so a redirect or a freed
    // slot is followed by a request in the very next cycle; armed keeps it
    // low until the first edge after reset release.
    always_comb begin
        req = 1'b0;
        unique case (state)
            IDLE:    req = armed && (count < FULL) && !bus.redirect;
            REQ,
            DISCARD: req = 1'b1;
            default: req = 1'b0;
        endcase
        take        = req && bus.mem_ack;
        push        = take && (state != DISCARD) && !bus.redirect;
        pop         = (count != '0) && !bus.mc__more_2a && !bus.mc__stall && !bus.redirect;
        count_nxt   = bus.redirect ? '0 : count + CNT_W'(push) - CNT_W'(pop);
        space_after = count_nxt < FULL;
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        unique case (state)
            IDLE: begin
                if (bus.redirect) begin
                    addr_nxt = bus.redirect_pc;
                end else if (take) begin
                    addr_nxt  = addr + 1'b1;
                    state_nxt = space_after ? REQ : IDLE;
                end else if (req) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (bus.redirect) begin
                    // An unacked request cannot be withdrawn; wait it out in DISCARD.
                    if (take) begin
                        addr_nxt  = bus.redirect_pc;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = DISCARD;
                    end
                end else if (take) begin
                    addr_nxt  = addr + 1'b1;
                    state_nxt = space_after ? REQ : IDLE;
                end
            end
            DISCARD: begin
                if (take) begin
                    addr_nxt  = bus.redirect ? bus.redirect_pc : target;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state  <= IDLE;
            armed  <= 1'b0;
            addr   <= RESET_PC;
            target <= RESET_PC;
            pc     <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
            addr  <= addr_nxt;
            count <= count_nxt;
            if (bus.redirect) begin
                target <= bus.redirect_pc;
                pc     <= bus.redirect_pc;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (pop) begin
                    pc     <= pc + 1'b1;
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (push) wr_ptr <= wr_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= bus.mem_rdata;
    end

    assign bus.mem_req      = req;
    assign bus.mem_addr     = addr;
    assign bus.opcode_valid = (count != '0);
    assign bus.opcode       = (count != '0) ? fifo[rd_ptr] : NOP_OPCODE;
    assign bus.opcode_pc    = pc;
endmodule
